aes_stream_io: RTL and testbench
================================

Name: aes_stream_io

Overview:
Streaming front/back end for the combinational AES-128 encryption core. It gathers four 32-bit plaintext words into a 128-bit block and holds the cipher key, both driven straight into the core's plaintext/key inputs. It waits a fixed settle time for the core's combinational path, then captures the core's ciphertext. It returns the ciphertext as four 32-bit words over a valid/ready stream. Processing is one block at a time, non-overlapped.

Parameters:
SETTLE_CYCLES, 2, clock edges between the last plaintext word accept and ciphertext capture; legal range 1..15.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous reset, active-high.
key_in  input  128  cipher key.
key_load  input  1  key capture strobe.
in_data  input  32  plaintext word.
in_valid  input  1  plaintext word valid.
in_ready  output  1  block accepts a plaintext word.
out_data  output  32  ciphertext word.
out_valid  output  1  ciphertext word valid.
out_ready  input  1  downstream accepts a word.
core_plaintext  output  128  to core plaintext input.
core_key  output  128  to core key input.
core_ciphertext  input  128  from core ciphertext output.
busy  output  1  high in SETTLE or UNLOAD.

Behaviour:
- Reset (async, active-high): state LOAD; word counter 0; settle counter 0; core_plaintext, core_key, out buffer all 0. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- Handshakes: a transfer occurs on a rising edge with valid&&ready. out_valid and out_data are held stable until the transfer. out_valid never depends combinationally on out_ready. in_ready is a pure function of state.
- Word order is FIPS-197 big-endian. Input word 0 goes to core_plaintext[127:96], word 3 to [31:0]. Output word 0 is ciphertext[127:96].
- State LOAD:
  - in_ready=1.
  - Each accepted word is written into its slot of core_plaintext; word_cnt increments.
  - Accepting word 3 sets word_cnt=0 and moves to SETTLE with settle_cnt=SETTLE_CYCLES-1.
  - Bubbles (in_valid low) just hold state.
- State SETTLE:
  - in_ready=0, busy=1.
  - settle_cnt decrements each edge.
  - On the edge where settle_cnt==0: core_ciphertext goes into the out buffer and the state moves to UNLOAD.
  - Net effect: capture happens SETTLE_CYCLES edges after the last-word accept edge. With SETTLE_CYCLES=2, out_valid is first high two cycles after that edge.
- State UNLOAD:
  - out_valid=1, busy=1, out_data = buffer word selected by out_cnt.
  - Each output transfer increments out_cnt.
  - The transfer of word 3 sets out_cnt=0, clears out_valid and returns to LOAD; in_ready=1 the following cycle.
  - out_ready low holds word and state indefinitely.
- Key:
  - key_load is honoured only in LOAD with word_cnt==0, and then captures key_in into core_key.
  - In any other state or count it is ignored and core_key is unchanged.
  - If key_load coincides with acceptance of word 0, both take effect and the new key applies to that block.
  - core_key persists across blocks until reloaded.
- core_plaintext and core_key remain stable from the last-word accept through capture. They are not cleared after a block.
- Throughput with no stalls: 4 + SETTLE_CYCLES + 4 cycles per block.
- Reset asserted mid-operation (any state) aborts the block immediately. A partially loaded or unloaded block is discarded, and no out_valid pulse follows after reset release.
- Counter widths: word_cnt and out_cnt are 2 bits and wrap naturally. settle_cnt is 4 bits.

Test Plan:
- FIPS-197 vector, with the real core connected:
  - Stimulus: key_load with key 000102030405060708090a0b0c0d0e0f; then words 00112233, 44556677, 8899aabb, ccddeeff back-to-back.
  - Response: out_valid rises 2 cycles after the fourth accept; words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, in order.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles, then toggle it 1/0.
  - Response: out_data stays 69c4e0d8 while stalled; exactly 4 transfers occur, no word is repeated or skipped; in_ready=0 until after the fourth transfer.
- Input bubbles and key gating:
  - Stimulus: insert 3-cycle in_valid gaps between words; assert key_load with all-FF after word 1.
  - Response: core_key is unchanged, and the ciphertext equals that of the original key.
- Back-to-back blocks:
  - Stimulus: a second block with plaintext all-zero under the FIPS key.
  - Response: 4 output words matching a software model, and core_key is retained without a reload.
- Reset mid-block:
  - Stimulus: assert rst after 2 words are loaded, and again during UNLOAD after 1 output word.
  - Response: out_valid=0 and all regs 0 immediately (asynchronously); the next full block produces correct output.
- SETTLE_CYCLES=1 and 15:
  - Response: capture latency is exactly 1 and 15 edges respectively.

Source files
------------

// File: rtl/aes_stream_io.sv
// aes_stream_io: valid/ready word stream around a combinational AES-128 core.
// Packs four plaintext words, waits SETTLE_CYCLES for the core, then unloads four ciphertext words.
module aes_stream_io #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic [127:0] core_ciphertext,
  output logic         busy
);
  typedef enum logic [1:0] {LOAD, SETTLE, UNLOAD} state_e;
  state_e state_q, state_d;
  logic [1:0] word_cnt_q, word_cnt_d, out_cnt_q, out_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [3:0][31:0] pt_q, pt_d, buf_q, buf_d;
  logic [127:0] key_q, key_d;
  logic in_fire, out_fire;
  assign in_ready = state_q == LOAD;
  assign out_valid = state_q == UNLOAD;
  assign busy = state_q != LOAD;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // Word 0 is the most significant word, so the packed slot index is the inverted counter.
  assign out_data = out_valid ? buf_q[~out_cnt_q] : '0;
  assign core_plaintext = pt_q;
  assign core_key = key_q;
  always_comb begin
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    out_cnt_d = out_cnt_q;
    settle_cnt_d = settle_cnt_q;
    pt_d = pt_q;
    buf_d = buf_q;
    key_d = (in_ready && word_cnt_q == 2'd0 && key_load) ? key_in : key_q;
    if (in_fire) begin
      pt_d[~word_cnt_q] = in_data;
      word_cnt_d = word_cnt_q + 2'd1;
      if (word_cnt_q == 2'd3) begin
        state_d = SETTLE;
        settle_cnt_d = 4'(SETTLE_CYCLES - 1);
      end
    end
    if (state_q == SETTLE) begin
      settle_cnt_d = settle_cnt_q - 4'd1;
      if (settle_cnt_q == 4'd0) begin
        settle_cnt_d = '0;
        buf_d = core_ciphertext;
        state_d = UNLOAD;
      end
    end
    if (out_fire) begin
      out_cnt_d = out_cnt_q + 2'd1;
      if (out_cnt_q == 2'd3) state_d = LOAD;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      word_cnt_q <= '0;
      out_cnt_q <= '0;
      settle_cnt_q <= '0;
      pt_q <= '0;
      buf_q <= '0;
      key_q <= '0;
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      out_cnt_q <= out_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pt_q <= pt_d;
      buf_q <= buf_d;
      key_q <= key_d;
    end
  end
endmodule

// File: tb/tb_aes_stream_io.sv
// tb_aes_stream_io: bench for aes_stream_io with a behavioural AES-128 core on each instance.
// Instances with SETTLE_CYCLES 2, 1 and 15 share stimulus; instance 0 is scoreboarded.
module tb_aes_stream_io;
  logic clk = 0, rst = 1;
  logic [127:0] key_in = '0;
  logic key_load = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic ir0, ov0, bz0, ir1, ov1, bz1, ir2, ov2, bz2;
  logic [31:0] od0, od1, od2;
  logic [127:0] pt0, kk0, ct0, pt1, kk1, ct1, pt2, kk2, ct2;
  int n_cmp = 0, n_fail = 0, n_xfer = 0;
  logic [31:0] q[$];
  localparam logic [127:0] KF = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PF = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CF = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xt(x);
    end
    return r;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gm(p, p);
      r = gm(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w[44];
    logic [7:0] s[16], t[16], rc, a0, a1, a2, a3;
    logic [31:0] tw;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb(tw[23:16]), sb(tw[15:8]), sb(tw[7:0]), sb(tw[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb(s[((i/4 + i%4) % 4)*4 + i%4]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  always_comb ct0 = aes_enc(pt0, kk0);
  always_comb ct1 = aes_enc(pt1, kk1);
  always_comb ct2 = aes_enc(pt2, kk2);

  aes_stream_io #(.SETTLE_CYCLES(2)) dut (.clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir0), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .core_plaintext(pt0), .core_key(kk0), .core_ciphertext(ct0), .busy(bz0));
  aes_stream_io #(.SETTLE_CYCLES(1)) dut_s1 (.clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir1), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .core_plaintext(pt1), .core_key(kk1), .core_ciphertext(ct1), .busy(bz1));
  aes_stream_io #(.SETTLE_CYCLES(15)) dut_s15 (.clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir2), .out_data(od2), .out_valid(ov2),
    .out_ready(out_ready), .core_plaintext(pt2), .core_key(kk2), .core_ciphertext(ct2), .busy(bz2));

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov0 && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", {96'h0, od0}, '1);
      else chk("out_word", {96'h0, od0}, {96'h0, q.pop_front()});
      n_xfer++;
    end
  end

  task automatic push_exp(input logic [127:0] c);
    for (int w = 0; w < 4; w++) q.push_back(c[127-32*w -: 32]);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_ready"}, ir0, 1);
    chk({nm, "_out_valid"}, ov0, 0);
    chk({nm, "_out_data"}, od0, 0);
    chk({nm, "_busy"}, bz0, 0);
    chk({nm, "_core_pt"}, pt0, 0);
    chk({nm, "_core_key"}, kk0, 0);
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key, input logic ld,
                            input int gap, input logic bogus);
    for (int w = 0; w < 4; w++) begin
      in_data = pt[127-32*w -: 32];
      in_valid = 1;
      key_in = key;
      key_load = (w == 0) && ld;
      @(posedge clk); #1;
      in_valid = 0;
      key_load = 0;
      if (bogus && w == 1) begin
        key_in = '1;
        key_load = 1;
        @(posedge clk); #1;
        key_load = 0;
      end
      if (w < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((bz0 || q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, q.size(), 0);
    chk({nm, "_in_ready"}, ir0, 1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic ld;
    logic [127:0] pt;
    int gap;
    logic bogus;
    logic [127:0] kexp;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat0, lat1, lat2, base, bad;
    tbl[0] = '{key: '1, ld: 0, pt: PF, gap: 3, bogus: 1, kexp: KF, exp: CF};
    tbl[1] = '{key: KF, ld: 0, pt: '0, gap: 0, bogus: 0, kexp: KF, exp: aes_enc('0, KF)};
    tbl[2] = '{key: K2, ld: 1, pt: P2, gap: 1, bogus: 0, kexp: K2, exp: C2};
    tbl[3] = '{key: K2, ld: 0, pt: '1, gap: 1, bogus: 1, kexp: K2, exp: aes_enc('1, K2)};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset("reset");
    // Latency on all three instances, then a long stall and a toggling drain on instance 0.
    @(posedge clk); #1;
    key_in = KF; key_load = 1;
    @(posedge clk); #1;
    key_load = 0;
    chk("key_loaded", kk0, KF);
    push_exp(CF);
    send_block(PF, KF, 0, 0, 0);
    lat0 = 0; lat1 = 0; lat2 = 0; bad = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (lat0 == 0 && ov0) lat0 = n;
      if (lat1 == 0 && ov1) lat1 = n;
      if (lat2 == 0 && ov2) lat2 = n;
      if (n >= 2 && od0 !== CF[127:96]) bad++;
    end
    chk("latency_s2", lat0, 2);
    chk("latency_s1", lat1, 1);
    chk("latency_s15", lat2, 15);
    chk("stall_hold_errors", bad, 0);
    chk("s1_word0", od1, CF[127:96]);
    chk("s15_word0", od2, CF[127:96]);
    base = n_xfer; bad = 0;
    for (int n = 0; n < 40 && !(n_xfer - base == 4 && ir0); n++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
      if (n_xfer - base < 4 && ir0) bad++;
    end
    out_ready = 1;
    chk("bp_transfers", n_xfer - base, 4);
    chk("bp_early_in_ready", bad, 0);
    chk("bp_in_ready_after", ir0, 1);
    chk("bp_queue_empty", q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      push_exp(tbl[i].exp);
      send_block(tbl[i].pt, tbl[i].key, tbl[i].ld, tbl[i].gap, tbl[i].bogus);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_core_key", i), kk0, tbl[i].kexp);
    end
    // Reset after two loaded words.
    in_data = P2[127:96]; in_valid = 1; key_in = KF; key_load = 1;
    @(posedge clk); #1;
    in_data = P2[95:64]; key_load = 0;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    #1 check_reset("rst_load");
    @(posedge clk); #1;
    rst = 0;
    push_exp(aes_enc(P2, KF));
    send_block(P2, KF, 1, 0, 0);
    wait_idle("after_rst_load");
    // Reset during unload after one transferred word.
    out_ready = 0;
    push_exp(C2);
    send_block(P2, K2, 1, 0, 0);
    for (int n = 0; n < 30 && !ov0; n++) begin @(posedge clk); #1; end
    chk("unload_valid", ov0, 1);
    base = n_xfer;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("unload_one_xfer", n_xfer - base, 1);
    rst = 1;
    q.delete();
    #1 check_reset("rst_unload");
    @(posedge clk); #1;
    rst = 0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ov0) bad++;
    end
    chk("no_valid_after_rst", bad, 0);
    @(posedge clk); #1;
    out_ready = 1;
    push_exp(aes_enc('0, K2));
    send_block('0, K2, 1, 0, 0);
    wait_idle("after_rst_unload");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
